uart_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the single UART MMIO slave between the core data port and the debug/test port. It sits between the two `MemPort` masters and the UART wrapper's `MemPort.Slave`. It allows exactly one outstanding transaction and routes each response back to the requester that issued it. A watchdog synthesizes an error response if the UART never answers.

---
 rtl/uart_arbiter.sv | 120 ++++++++++++
 tb/tb_uart_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_arbiter.sv
// Two-requester round-robin arbiter in front of the UART MMIO slave.
// One transaction outstanding at a time; a watchdog answers if the UART stays silent.
module uart_arbiter #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  // m0: core requester
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_write_en,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  // m1: debug requester
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_write_en,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  // toward the UART wrapper
  output logic        to_uart_valid,
  input  logic        to_uart_ready,
  output logic        to_uart_write_en,
  output logic [31:0] to_uart_addr,
  output logic [31:0] to_uart_wdata,
  input  logic        to_uart_rvalid,
  input  logic [31:0] to_uart_rdata,
  output logic        timeout_o,
  output logic        owner_o,
  output logic        busy_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // The counter holds the number of WAIT cycles already elapsed, so the
  // watchdog fires in the cycle TIMEOUT after the acceptance cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;
  logic        last_reg, last_next;
  logic [7:0]  cnt_reg, cnt_next;

  logic        arb_en, gnt_valid, gnt, accept, resp_ok, resp_tmo;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_data;

  always_comb begin
    arb_en           = !rst && ((state_reg == S_IDLE) || to_uart_rvalid);
    gnt              = (m0_valid && m1_valid) ? ~last_reg : m1_valid;
    gnt_valid        = arb_en && (m0_valid || m1_valid);
    to_uart_valid    = gnt_valid;
    to_uart_write_en = 1'b0;
    to_uart_addr     = '0;
    to_uart_wdata    = '0;
    if (gnt_valid) begin
      to_uart_write_en = gnt ? m1_write_en : m0_write_en;
      to_uart_addr     = gnt ? m1_addr     : m0_addr;
      to_uart_wdata    = gnt ? m1_wdata    : m0_wdata;
    end
    accept   = gnt_valid && to_uart_ready;
    resp_ok  = !rst && (state_reg == S_WAIT) && to_uart_rvalid;
    resp_tmo = !rst && (state_reg == S_WAIT) && !to_uart_rvalid && (cnt_reg == CNT_LAST);
    rsp_data = resp_tmo ? ERR_DATA : (resp_ok ? to_uart_rdata : 32'h0);

    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    if (accept) begin
      state_next = S_WAIT;
      owner_next = gnt;
      last_next  = gnt;
      cnt_next   = '0;
    end else if (resp_ok || resp_tmo) begin
      state_next = S_IDLE;
    end else if ((state_reg == S_WAIT) && (cnt_reg != CNT_LAST)) begin
      cnt_next = cnt_reg + 8'd1;
    end
  end

  // Per-requester handshake and response routing.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_ready[gi] = gnt_valid && (gnt == 1'(gi)) && to_uart_ready;
      assign rsp_valid[gi] = (resp_ok || resp_tmo) && (owner_reg == 1'(gi));
    end
  endgenerate

  assign m0_ready  = req_ready[0];
  assign m1_ready  = req_ready[1];
  assign m0_rvalid = rsp_valid[0];
  assign m1_rvalid = rsp_valid[1];
  assign m0_rdata  = rsp_valid[0] ? rsp_data : 32'h0;
  assign m1_rdata  = rsp_valid[1] ? rsp_data : 32'h0;
  assign timeout_o = resp_tmo;
  assign owner_o   = owner_reg;
  assign busy_o    = (state_reg == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter with a tiny UART wrapper model
// (ready = valid, rvalid one cycle later) plus manual ready/rvalid injection.
module tb_uart_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m0_ready, m0_write_en, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_valid, m1_ready, m1_write_en, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        to_uart_valid, to_uart_ready, to_uart_write_en, to_uart_rvalid;
  logic [31:0] to_uart_addr, to_uart_wdata, to_uart_rdata;
  logic        timeout_o, owner_o, busy_o;

  // UART model controls
  logic        auto_mode, man_ready, inj_rvalid;
  logic [31:0] inj_rdata, resp_data;
  logic        rv_q = 1'b0;
  logic [31:0] rd_q = 32'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign to_uart_ready  = auto_mode ? to_uart_valid : man_ready;
  assign to_uart_rvalid = rv_q | inj_rvalid;
  assign to_uart_rdata  = rv_q ? rd_q : inj_rdata;

  always @(posedge clk) begin
    rv_q <= auto_mode && to_uart_valid && to_uart_ready;
    rd_q <= resp_data;
  end

  uart_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_write_en(m0_write_en),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_write_en(m1_write_en),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .to_uart_valid(to_uart_valid), .to_uart_ready(to_uart_ready),
    .to_uart_write_en(to_uart_write_en), .to_uart_addr(to_uart_addr),
    .to_uart_wdata(to_uart_wdata), .to_uart_rvalid(to_uart_rvalid),
    .to_uart_rdata(to_uart_rdata),
    .timeout_o(timeout_o), .owner_o(owner_o), .busy_o(busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_valid = 1'b1; m0_write_en = 1'b0; m0_addr = 32'h4; m0_wdata = 32'h0;
    m1_valid = 1'b0; m1_write_en = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    auto_mode = 1'b1; man_ready = 1'b0; inj_rvalid = 1'b0; inj_rdata = 32'h0;
    resp_data = 32'h0;

    // Reset state: no ready even with a pending request
    settle;
    check_eq("rst_m0_ready", 32'(m0_ready), 0);
    check_eq("rst_busy", 32'(busy_o), 0);
    check_eq("rst_owner", 32'(owner_o), 0);
    check_eq("rst_timeout", 32'(timeout_o), 0);
    check_eq("rst_m0_rvalid", 32'(m0_rvalid), 0);
    next_cycle;
    rst = 1'b0; m0_valid = 1'b0;
    settle;
    next_cycle;

    // Single read
    m0_valid = 1'b1; m0_addr = 32'h004; resp_data = 32'h5A;
    settle;
    check_eq("rd_m0_ready", 32'(m0_ready), 1);
    check_eq("rd_uart_addr", to_uart_addr, 32'h004);
    check_eq("rd_busy0", 32'(busy_o), 0);
    next_cycle;
    m0_valid = 1'b0;
    settle;
    check_eq("rd_m0_rvalid", 32'(m0_rvalid), 1);
    check_eq("rd_m0_rdata", m0_rdata, 32'h5A);
    check_eq("rd_m1_rvalid", 32'(m1_rvalid), 0);
    check_eq("rd_busy1", 32'(busy_o), 1);
    next_cycle;
    settle;
    check_eq("rd_busy2", 32'(busy_o), 0);
    next_cycle;

    // Re-reset so the tie starts from last = 1
    rst = 1'b1;
    settle;
    next_cycle;
    rst = 1'b0;

    // Tie fairness: both hold valid for 4 transactions
    m0_valid = 1'b1; m0_addr = 32'h10;
    m1_valid = 1'b1; m1_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      settle;
      if (k[0] == 1'b0) begin
        check_eq($sformatf("tie%0d_m0_ready", k), 32'(m0_ready), 1);
        check_eq($sformatf("tie%0d_m1_ready", k), 32'(m1_ready), 0);
        check_eq($sformatf("tie%0d_addr", k), to_uart_addr, 32'h10);
      end else begin
        check_eq($sformatf("tie%0d_m1_ready", k), 32'(m1_ready), 1);
        check_eq($sformatf("tie%0d_m0_ready", k), 32'(m0_ready), 0);
        check_eq($sformatf("tie%0d_addr", k), to_uart_addr, 32'h20);
      end
      if (k > 0) begin
        check_eq($sformatf("tie%0d_prev_owner", k), 32'(owner_o), 32'(k[0] ? 0 : 1));
        check_eq($sformatf("tie%0d_prev_rvalid", k),
                 32'(k[0] ? m0_rvalid : m1_rvalid), 1);
      end
      next_cycle;
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    settle;
    check_eq("tie_last_m1_rvalid", 32'(m1_rvalid), 1);
    check_eq("tie_last_m0_rvalid", 32'(m0_rvalid), 0);
    next_cycle;

    // Back-to-back writes from m1
    m1_valid = 1'b1; m1_write_en = 1'b1; m1_addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      m1_wdata = 32'h41 + 32'(k);
      settle;
      check_eq($sformatf("b2b%0d_m1_ready", k), 32'(m1_ready), 1);
      check_eq($sformatf("b2b%0d_wdata", k), to_uart_wdata, 32'h41 + 32'(k));
      check_eq($sformatf("b2b%0d_we", k), 32'(to_uart_write_en), 1);
      check_eq($sformatf("b2b%0d_busy", k), 32'(busy_o), 32'(k > 0));
      check_eq($sformatf("b2b%0d_m1_rvalid", k), 32'(m1_rvalid), 32'(k > 0));
      next_cycle;
    end
    m1_valid = 1'b0; m1_write_en = 1'b0;
    settle;
    check_eq("b2b_final_rvalid", 32'(m1_rvalid), 1);
    check_eq("b2b_final_busy", 32'(busy_o), 1);
    next_cycle;
    settle;
    check_eq("b2b_idle_busy", 32'(busy_o), 0);
    next_cycle;

    // Timeout: UART accepts but never answers
    auto_mode = 1'b0; man_ready = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h8; m0_write_en = 1'b0;
    settle;
    check_eq("to_m0_ready", 32'(m0_ready), 1);
    next_cycle;
    m0_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      settle;
      check_eq($sformatf("to_wait%0d_rvalid", k), 32'(m0_rvalid), 0);
      check_eq($sformatf("to_wait%0d_timeout", k), 32'(timeout_o), 0);
      next_cycle;
    end
    settle;
    check_eq("to_fire_rvalid", 32'(m0_rvalid), 1);
    check_eq("to_fire_rdata", m0_rdata, 32'hDEADBEEF);
    check_eq("to_fire_timeout", 32'(timeout_o), 1);
    check_eq("to_fire_m1_rvalid", 32'(m1_rvalid), 0);
    next_cycle;
    settle;
    check_eq("to_after_timeout", 32'(timeout_o), 0);
    check_eq("to_after_busy", 32'(busy_o), 0);
    next_cycle;
    inj_rvalid = 1'b1; inj_rdata = 32'h77;
    settle;
    check_eq("to_late_m0_rvalid", 32'(m0_rvalid), 0);
    check_eq("to_late_m1_rvalid", 32'(m1_rvalid), 0);
    check_eq("to_late_m0_rdata", m0_rdata, 32'h0);
    next_cycle;
    inj_rvalid = 1'b0;

    // Reset mid-transaction
    m1_valid = 1'b1; m1_addr = 32'h30;
    settle;
    check_eq("rm_m1_ready", 32'(m1_ready), 1);
    next_cycle;
    m1_valid = 1'b0;
    settle;
    check_eq("rm_owner", 32'(owner_o), 1);
    check_eq("rm_busy", 32'(busy_o), 1);
    next_cycle;
    rst = 1'b1; inj_rvalid = 1'b1; inj_rdata = 32'h99;
    settle;
    check_eq("rm_rst_m1_rvalid", 32'(m1_rvalid), 0);
    check_eq("rm_rst_m1_rdata", m1_rdata, 32'h0);
    next_cycle;
    rst = 1'b0;
    settle;
    check_eq("rm_after_m1_rvalid", 32'(m1_rvalid), 0);
    check_eq("rm_after_busy", 32'(busy_o), 0);
    check_eq("rm_after_owner", 32'(owner_o), 0);
    next_cycle;
    inj_rvalid = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h40;
    m1_valid = 1'b1; m1_addr = 32'h50;
    settle;
    check_eq("rm_tie_m0_ready", 32'(m0_ready), 1);
    check_eq("rm_tie_m1_ready", 32'(m1_ready), 0);
    next_cycle;
    m0_valid = 1'b0; m1_valid = 1'b0;
    inj_rvalid = 1'b1; inj_rdata = 32'h31;
    settle;
    check_eq("rm_tie_m0_rvalid", 32'(m0_rvalid), 1);
    check_eq("rm_tie_m0_rdata", m0_rdata, 32'h31);
    next_cycle;
    inj_rvalid = 1'b0;

    // Withdrawn request from m1 while the UART stalls
    man_ready = 1'b0;
    m1_valid = 1'b1; m1_addr = 32'h60;
    for (int k = 0; k < 2; k++) begin
      settle;
      check_eq($sformatf("wd%0d_m1_ready", k), 32'(m1_ready), 0);
      check_eq($sformatf("wd%0d_uart_addr", k), to_uart_addr, 32'h60);
      check_eq($sformatf("wd%0d_busy", k), 32'(busy_o), 0);
      next_cycle;
    end
    m1_valid = 1'b0; m0_valid = 1'b1; m0_addr = 32'h70; man_ready = 1'b1;
    settle;
    check_eq("wd_m0_ready", 32'(m0_ready), 1);
    check_eq("wd_m1_ready", 32'(m1_ready), 0);
    check_eq("wd_uart_addr", to_uart_addr, 32'h70);
    next_cycle;
    m0_valid = 1'b0; inj_rvalid = 1'b1; inj_rdata = 32'h12;
    settle;
    check_eq("wd_owner", 32'(owner_o), 0);
    check_eq("wd_m0_rvalid", 32'(m0_rvalid), 1);
    check_eq("wd_m1_rvalid", 32'(m1_rvalid), 0);
    next_cycle;
    inj_rvalid = 1'b0;
    settle;
    check_eq("wd_end_busy", 32'(busy_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
